// File: rtl/issue_queue_pkg.sv
// Shared types and constants for the in-order issue queue between decode and dispatch.
// Elements are opaque 32-bit decoded micro-ops; the queue never inspects their contents.
package issue_queue_pkg;

    localparam int IQ_DEPTH     = 16;
    localparam int ELEM_W       = 32;
    localparam int DECODE_WIDTH = 4;

    typedef logic [ELEM_W-1:0] issue_queue_element_t;

endpackage

// File: rtl/iq_ptr_ctrl.sv
// Head/tail/count bookkeeping for the issue queue: legality of push and pop groups,
// pointer advance, flush/reset recovery and the one-cycle error pulses.
module iq_ptr_ctrl #(
    parameter int DEPTH     = 16,
    parameter int POP_WIDTH = 2,
    parameter int PTR_W     = $clog2(DEPTH),
    parameter int HVN_W     = $clog2(POP_WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [2:0]         push_number,
    input  logic [HVN_W-1:0]   pop_number,
    output logic [PTR_W-1:0]   head,
    output logic [PTR_W-1:0]   tail,
    output logic [PTR_W:0]     free,
    output logic [HVN_W-1:0]   head_valid_number,
    output logic               push_we,
    output logic               push_overflow,
    output logic               pop_underflow
);
    localparam int CNT_W = PTR_W + 1;

    logic [CNT_W-1:0] count;
    logic             push_ok;
    logic             pop_ok;
    logic [2:0]       n_acc;
    logic [HVN_W-1:0] p_acc;

    // Legality uses start-of-cycle occupancy only, so slots freed by a same-cycle pop
    // are not reusable until the next cycle.
    assign free              = CNT_W'(DEPTH) - count;
    assign push_ok           = (push_number <= 3'd4) && (CNT_W'(push_number) <= free);
    assign head_valid_number = (count >= CNT_W'(POP_WIDTH)) ? HVN_W'(POP_WIDTH) : HVN_W'(count);
    assign pop_ok            = (pop_number <= head_valid_number);
    assign n_acc             = push_ok ? push_number : 3'd0;
    assign p_acc             = pop_ok ? pop_number : '0;
    assign push_we           = push_ok && !flush && !rst;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            push_overflow <= 1'b0;
            pop_underflow <= 1'b0;
        end else begin
            head          <= head + PTR_W'(p_acc);
            tail          <= tail + PTR_W'(n_acc);
            count         <= count + CNT_W'(n_acc) - CNT_W'(p_acc);
            push_overflow <= !push_ok;
            pop_underflow <= !pop_ok;
        end
    end

endmodule

// File: rtl/issue_queue.sv
// In-order circular issue queue: storage array plus head read muxing; pointer and
// legality bookkeeping lives in iq_ptr_ctrl.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int DEPTH     = IQ_DEPTH,
    parameter int POP_WIDTH = 2,
    parameter int PTR_W     = $clog2(DEPTH)
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     flush,
    input  logic [DECODE_WIDTH-1:0][ELEM_W-1:0]      issue_queue_element,
    input  logic [2:0]                               issue_queue_push_number,
    output logic [2:0]                               iq_size_left,
    output logic [POP_WIDTH-1:0][ELEM_W-1:0]         head_element,
    output logic [$clog2(POP_WIDTH+1)-1:0]           head_valid_number,
    input  logic [$clog2(POP_WIDTH+1)-1:0]           pop_number,
    output logic                                     push_overflow,
    output logic                                     pop_underflow
);
    localparam int HVN_W = $clog2(POP_WIDTH + 1);

    issue_queue_element_t mem [DEPTH];
    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;
    logic [PTR_W:0]       free;
    logic                 push_we;

    iq_ptr_ctrl #(
        .DEPTH     (DEPTH),
        .POP_WIDTH (POP_WIDTH),
        .PTR_W     (PTR_W),
        .HVN_W     (HVN_W)
    ) u_ptr_ctrl (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .push_number       (issue_queue_push_number),
        .pop_number        (pop_number),
        .head              (head),
        .tail              (tail),
        .free              (free),
        .head_valid_number (head_valid_number),
        .push_we           (push_we),
        .push_overflow     (push_overflow),
        .pop_underflow     (pop_underflow)
    );

    assign iq_size_left = (free >= (PTR_W+1)'(4)) ? 3'd4 : free[2:0];

    // A push group may straddle the last index; the pointer add wraps naturally.
    always_ff @(posedge clk) begin
        if (push_we) begin
            for (int i = 0; i < DECODE_WIDTH; i++) begin
                if (3'(i) < issue_queue_push_number)
                    mem[tail + PTR_W'(i)] <= issue_queue_element[i];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < POP_WIDTH; k++)
            head_element[k] = mem[head + PTR_W'(k)];
    end

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: directed test-plan scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_issue_queue;
    localparam int DEPTH     = 16;
    localparam int POP_WIDTH = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic                flush;
    logic [3:0][31:0]    issue_queue_element;
    logic [2:0]          issue_queue_push_number;
    logic [2:0]          iq_size_left;
    logic [1:0][31:0]    head_element;
    logic [1:0]          head_valid_number;
    logic [1:0]          pop_number;
    logic                push_overflow;
    logic                pop_underflow;

    int errors = 0;
    int checks = 0;

    logic [31:0] model_q[$];
    logic        exp_po;
    logic        exp_pu;

    issue_queue #(.DEPTH(DEPTH), .POP_WIDTH(POP_WIDTH)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .flush                   (flush),
        .issue_queue_element     (issue_queue_element),
        .issue_queue_push_number (issue_queue_push_number),
        .iq_size_left            (iq_size_left),
        .head_element            (head_element),
        .head_valid_number       (head_valid_number),
        .pop_number              (pop_number),
        .push_overflow           (push_overflow),
        .pop_underflow           (pop_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        int free;
        int hvn;
        free = DEPTH - model_q.size();
        hvn  = (model_q.size() < POP_WIDTH) ? model_q.size() : POP_WIDTH;
        chk("size_left", 32'(iq_size_left), 32'((free > 4) ? 4 : free));
        chk("head_valid", 32'(head_valid_number), 32'(hvn));
        for (int k = 0; k < hvn; k++)
            chk($sformatf("head_elem%0d", k), head_element[k], model_q[k]);
        chk("push_overflow", 32'(push_overflow), 32'(exp_po));
        chk("pop_underflow", 32'(pop_underflow), 32'(exp_pu));
    endtask

    // Drives one cycle (elements taken from issue_queue_element as set by the caller),
    // advances the model from its start-of-cycle state, then checks after the edge.
    task automatic step(input int n, input int p, input bit f, input bit r);
        int  free;
        int  hvn;
        bit  push_ok;
        bit  pop_ok;
        issue_queue_push_number = 3'(n);
        pop_number              = 2'(p);
        flush                   = f;
        rst                     = r;
        free    = DEPTH - model_q.size();
        hvn     = (model_q.size() < POP_WIDTH) ? model_q.size() : POP_WIDTH;
        push_ok = (n <= 4) && (n <= free);
        pop_ok  = (p <= hvn);
        @(posedge clk);
        if (r || f) begin
            model_q.delete();
            exp_po = 1'b0;
            exp_pu = 1'b0;
        end else begin
            if (pop_ok)
                for (int i = 0; i < p; i++) void'(model_q.pop_front());
            if (push_ok)
                for (int i = 0; i < n; i++) model_q.push_back(issue_queue_element[i]);
            exp_po = !push_ok;
            exp_pu = !pop_ok;
        end
        #1;
        check_model();
        issue_queue_push_number = 3'd0;
        pop_number              = 2'd0;
        flush                   = 1'b0;
        rst                     = 1'b0;
    endtask

    task automatic rand_elems();
        for (int i = 0; i < 4; i++) issue_queue_element[i] = $urandom;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        issue_queue_push_number = 3'd0;
        pop_number = 2'd0;
        exp_po = 1'b0;
        exp_pu = 1'b0;
        rand_elems();

        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("rst_size_left", 32'(iq_size_left), 32'd4);
        chk("rst_hvn", 32'(head_valid_number), 32'd0);

        for (int i = 0; i < 3; i++) begin rand_elems(); step(4, 0, 0, 0); end
        chk("fill12_left", 32'(iq_size_left), 32'd4);
        rand_elems(); step(4, 0, 0, 0);
        chk("fill16_left", 32'(iq_size_left), 32'd0);
        rand_elems(); step(1, 0, 0, 0);
        chk("full_overflow", 32'(push_overflow), 32'd1);
        chk("full_left", 32'(iq_size_left), 32'd0);

        step(0, 2, 0, 0);
        rand_elems(); step(3, 0, 0, 0);
        chk("partial_overflow", 32'(push_overflow), 32'd1);
        rand_elems(); step(2, 0, 0, 0);
        chk("partial_ok_left", 32'(iq_size_left), 32'd0);

        rand_elems(); step(2, 2, 0, 0);
        chk("simul_overflow", 32'(push_overflow), 32'd1);
        chk("simul_left", 32'(iq_size_left), 32'd2);

        step(0, 2, 0, 0);
        step(0, 2, 0, 0);
        step(0, 1, 0, 0);
        rand_elems(); step(4, 2, 1, 0);
        chk("flush_left", 32'(iq_size_left), 32'd4);
        chk("flush_hvn", 32'(head_valid_number), 32'd0);

        rand_elems(); step(4, 0, 0, 0);
        rand_elems(); step(4, 0, 0, 0);
        step(0, 3, 0, 0);
        chk("underflow", 32'(pop_underflow), 32'd1);
        chk("underflow_hvn", 32'(head_valid_number), 32'd2);

        step(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin rand_elems(); step(4, 0, 0, 0); end
        rand_elems(); step(2, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 2, 0, 0);
        chk("wrap_empty_hvn", 32'(head_valid_number), 32'd0);
        issue_queue_element[0] = 32'hA0A0_0001;
        issue_queue_element[1] = 32'hB0B0_0002;
        issue_queue_element[2] = 32'hC0C0_0003;
        issue_queue_element[3] = 32'hD0D0_0004;
        step(4, 0, 0, 0);
        chk("wrap_h0_A", head_element[0], 32'hA0A0_0001);
        chk("wrap_h1_B", head_element[1], 32'hB0B0_0002);
        step(0, 2, 0, 0);
        chk("wrap_h0_C", head_element[0], 32'hC0C0_0003);
        chk("wrap_h1_D", head_element[1], 32'hD0D0_0004);

        for (int c = 0; c < 3000; c++) begin
            rand_elems();
            step($urandom_range(0, 6), $urandom_range(0, 3),
                 ($urandom_range(0, 31) == 0), ($urandom_range(0, 127) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
